// File: rtl/instruction_encoder_pkg.sv
// Shared definitions for the instruction encoder and the decoder that consumes its stream:
// state encodings, header layout, default sync nibble and packet lengths.
package instruction_encoder_pkg;

    // FSM state encodings (plain constants so legacy tools can share them)
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_ADR  = 3'd2;
    localparam logic [2:0] ST_DHI  = 3'd3;
    localparam logic [2:0] ST_DLO  = 3'd4;
    localparam logic [2:0] ST_CHK  = 3'd5;

    // Header layout: {sync[15:12], 3'b000, rwn[8], 8'h00}
    localparam logic [3:0] SYNC_DEFAULT = 4'hA;
    localparam int         HDR_SYNC_MSB = 15;
    localparam int         HDR_SYNC_LSB = 12;
    localparam int         HDR_RWN_BIT  = 8;

    // Packet lengths in words, checksum included
    localparam int WORDS_WRITE = 5;
    localparam int WORDS_READ  = 3;

    // Build the header word for a given sync nibble and direction
    function automatic logic [15:0] make_header(input logic [3:0] sync, input logic rwn);
        logic [15:0] hdr;
        hdr = 16'h0000;
        hdr[HDR_SYNC_MSB:HDR_SYNC_LSB] = sync;
        hdr[HDR_RWN_BIT] = rwn;
        return hdr;
    endfunction

endpackage

// File: rtl/instruction_encoder_timeout.sv
// Stall watchdog: counts cycles a word waits without being taken and flags
// the cycle in which the wait reaches its last permitted cycle.
module instruction_encoder_timeout #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Expiry is only meaningful while the word is actually waiting
    assign expire_o = enable_i && (count_q == LAST);

    // Next count: clear on new word / transfer / abort, otherwise count waits
    always_comb begin
        count_d = count_q;
        if (clear_i || expire_o) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// Packs an address/data/direction request into HDR, ADR, [DHI, DLO,] CHK
// 16-bit words on a start/ready handshake, aborting if the consumer stalls.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int         TIMEOUT = 64,
    parameter logic [3:0] SYNC    = SYNC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rwn,
    input  logic [15:0] address_in,
    input  logic [31:0] data_in,
    output logic        ready,
    output logic        done,
    output logic        error,
    output logic        start_for_decoder,
    output logic [15:0] instruction_out,
    input  logic        ready_from_decoder
);

    logic [2:0]  state_q, state_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        sfd_q, sfd_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] chk_q, chk_d;
    logic        rwn_q, rwn_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;

    logic        accept_s;
    logic        transfer_s;
    logic        expire_s;
    logic [15:0] chk_next_s;

    assign accept_s   = ready_q && start;
    assign transfer_s = sfd_q && ready_from_decoder;
    assign chk_next_s = chk_q ^ instr_q;

    instruction_encoder_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (accept_s || transfer_s),
        .enable_i (sfd_q && !ready_from_decoder),
        .expire_o (expire_s)
    );

    // Next-state logic: accept, word sequencing, completion and abort
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        sfd_d   = sfd_q;
        instr_d = instr_q;
        chk_d   = chk_q;
        rwn_d   = rwn_q;
        addr_d  = addr_q;
        data_d  = data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    rwn_d   = rwn;
                    addr_d  = address_in;
                    data_d  = data_in;
                    chk_d   = 16'h0000;
                    ready_d = 1'b0;
                    sfd_d   = 1'b1;
                    instr_d = make_header(SYNC, rwn);
                    state_d = ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR, ST_ADR, ST_DHI, ST_DLO, ST_CHK: begin
                if (transfer_s) begin
                    chk_d = chk_next_s;
                    case (state_q)
                        ST_HDR: begin
                            instr_d = addr_q;
                            state_d = ST_ADR;
                        end
                        ST_ADR: begin
                            if (rwn_q) begin
                                instr_d = chk_next_s;
                                state_d = ST_CHK;
                            end else begin
                                instr_d = data_q[31:16];
                                state_d = ST_DHI;
                            end
                        end
                        ST_DHI: begin
                            instr_d = data_q[15:0];
                            state_d = ST_DLO;
                        end
                        ST_DLO: begin
                            instr_d = chk_next_s;
                            state_d = ST_CHK;
                        end
                        default: begin
                            // Checksum taken: packet complete
                            instr_d = 16'h0000;
                            sfd_d   = 1'b0;
                            ready_d = 1'b1;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    endcase
                end else if (expire_s) begin
                    // Consumer stalled too long: drop the packet
                    instr_d = 16'h0000;
                    sfd_d   = 1'b0;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                instr_d = 16'h0000;
                sfd_d   = 1'b0;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            sfd_q   <= 1'b0;
            instr_q <= 16'h0000;
            chk_q   <= 16'h0000;
            rwn_q   <= 1'b0;
            addr_q  <= 16'h0000;
            data_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            error_q <= error_d;
            sfd_q   <= sfd_d;
            instr_q <= instr_d;
            chk_q   <= chk_d;
            rwn_q   <= rwn_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign ready             = ready_q;
    assign done              = done_q;
    assign error             = error_q;
    assign start_for_decoder = sfd_q;
    assign instruction_out   = instr_q;

endmodule
